// File: rtl/j1_boot_pkg.sv
// Shared definitions for the J1 boot loader: FSM state encoding, field byte
// order and default code RAM geometry.
// Ports: none (package).
package j1_boot_pkg;

  localparam int CODE_AW_DEF    = 13;
  localparam int CODE_DEPTH_DEF = 8192;

  // LEN, data and SUM fields arrive as byte pairs, low byte first.
  localparam bit FIELD_LSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DAT_LO,
    DAT_HI,
    SUM_LO,
    SUM_HI,
    RUN,
    FAIL
  } boot_state_e;

  // Assemble a 16-bit field from its two stream bytes in arrival order.
  function automatic logic [15:0] pair_word(input logic [7:0] first_b,
                                            input logic [7:0] second_b);
    return FIELD_LSB_FIRST ? {second_b, first_b} : {first_b, second_b};
  endfunction

endpackage

// File: rtl/j1_boot_loader_if.sv
// Byte-stream input and code RAM write port of the J1 boot loader.
// Ports: rx_data/rx_valid/rx_ready (valid-ready byte stream),
//        code_we/code_waddr/code_wdata (code RAM write port).
interface j1_boot_loader_if #(
  parameter int CODE_AW = j1_boot_pkg::CODE_AW_DEF
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               code_we;
  logic [CODE_AW-1:0] code_waddr;
  logic [15:0]        code_wdata;

  // master: the loader; slave: byte source and code RAM.
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, code_we, code_waddr, code_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, code_we, code_waddr, code_wdata
  );
endinterface

// File: rtl/j1_boot_loader.sv
// Loads a length-prefixed, checksummed image from a byte stream into J1 code
// RAM and then releases the core from reset.
// Ports: clk, resetq (async active-low), boot_req (sync reload), bus (stream
//        in + code RAM write out), cpu_resetq/busy/done/err (registered status).
module j1_boot_loader
  import j1_boot_pkg::*;
#(
  parameter int CODE_AW    = CODE_AW_DEF,
  parameter int CODE_DEPTH = CODE_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                resetq,
  input  logic                boot_req,
  j1_boot_loader_if.master    bus,
  output logic                cpu_resetq,
  output logic                busy,
  output logic                done,
  output logic                err
);

  boot_state_e        state_q;
  logic [7:0]         lo_q;      // first byte of the pair being assembled
  logic [CODE_AW:0]   idx_q;     // one extra bit so a full-depth image does not wrap
  logic [CODE_AW:0]   len_q;
  logic [15:0]        sum_q;
  logic               code_we_q;
  logic [CODE_AW-1:0] code_waddr_q;
  logic [15:0]        code_wdata_q;
  logic               cpu_resetq_q, busy_q, done_q, err_q;

  logic               loading;
  logic               accept;
  logic [15:0]        rx_word;
  logic [CODE_AW:0]   idx_inc;

  assign loading  = (state_q != RUN) && (state_q != FAIL);
  // A reload request wins over any byte offered in the same cycle.
  assign bus.rx_ready = loading && !boot_req;
  assign accept   = bus.rx_valid && bus.rx_ready;
  assign rx_word  = pair_word(lo_q, bus.rx_data);
  assign idx_inc  = idx_q + {{CODE_AW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q      <= LEN_LO;
      lo_q         <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      sum_q        <= '0;
      code_we_q    <= 1'b0;
      code_waddr_q <= '0;
      code_wdata_q <= '0;
      cpu_resetq_q <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      code_we_q <= 1'b0;
      if (boot_req) begin
        state_q      <= LEN_LO;
        idx_q        <= '0;
        sum_q        <= '0;
        cpu_resetq_q <= 1'b0;
        busy_q       <= 1'b1;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
      end else if (accept) begin
        case (state_q)
          LEN_LO: begin
            lo_q    <= bus.rx_data;
            state_q <= LEN_HI;
          end
          LEN_HI: begin
            if (rx_word == 16'h0000) begin
              state_q <= SUM_LO;
            end else if (rx_word > 16'(CODE_DEPTH)) begin
              state_q <= FAIL;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              len_q   <= rx_word[CODE_AW:0];
              state_q <= DAT_LO;
            end
          end
          DAT_LO: begin
            lo_q    <= bus.rx_data;
            state_q <= DAT_HI;
          end
          DAT_HI: begin
            code_we_q    <= 1'b1;
            code_waddr_q <= idx_q[CODE_AW-1:0];
            code_wdata_q <= rx_word;
            idx_q        <= idx_inc;
            sum_q        <= sum_q + rx_word;
            state_q      <= (idx_inc == len_q) ? SUM_LO : DAT_LO;
          end
          SUM_LO: begin
            lo_q    <= bus.rx_data;
            state_q <= SUM_HI;
          end
          SUM_HI: begin
            busy_q <= 1'b0;
            if (rx_word == sum_q) begin
              state_q      <= RUN;
              cpu_resetq_q <= 1'b1;
              done_q       <= 1'b1;
            end else begin
              state_q <= FAIL;
              err_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.code_we    = code_we_q;
  assign bus.code_waddr = code_waddr_q;
  assign bus.code_wdata = code_wdata_q;
  assign cpu_resetq     = cpu_resetq_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: doc/j1_boot_loader.md
J1_BOOT_LOADER -- requirements
Module: j1_boot_loader

Interface
REQ-001 Parameter CODE_AW, default 13, code RAM word-address width; matches the core's code_addr width.
REQ-002 Parameter CODE_DEPTH, default 8192, maximum loadable image size in 16-bit words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 resetq  input  1  reset; asynchronous, active-low.
REQ-005 boot_req  input  1  synchronous restart request: reload the image.
REQ-006 rx_data  input  8  boot stream byte.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid & rx_ready at a rising edge.
REQ-009 code_we  output  1  code RAM write strobe.
REQ-010 code_waddr  output  CODE_AW  code RAM write word address.
REQ-011 code_wdata  output  16  code RAM write data.
REQ-012 cpu_resetq  output  1  active-low reset to the core; low while loading or failed.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  image loaded and verified; core running.
REQ-015 err  output  1  load failed.

Function
REQ-016 Stream format: little-endian byte pairs: length N (words), then N data words, then checksum word = sum of data words mod 2^16.
REQ-017 State machine states: LEN_LO, LEN_HI, DAT_LO, DAT_HI, SUM_LO, SUM_HI, RUN, FAIL; each *_LO/*_HI state consumes exactly one accepted byte.
REQ-018 rx_ready is 1 in LEN_LO through SUM_HI and 0 in RUN and FAIL; it is forced to 0 in any cycle where boot_req is 1.
REQ-019 LEN_HI accept: N=0 -> SUM_LO; N > CODE_DEPTH -> FAIL; otherwise -> DAT_LO.
REQ-020 DAT_HI accept: code_we is high for exactly one cycle on the following cycle, with code_wdata={hi,lo} and code_waddr=current word index; the index then increments and the word is added to the 16-bit running sum.
REQ-021 After the Nth data word, DAT_HI -> SUM_LO; otherwise DAT_HI -> DAT_LO.
REQ-022 SUM_HI accept: if {hi,lo} equals the running sum -> RUN, else -> FAIL.
REQ-023 cpu_resetq, busy, done and err are registered; they change on the same edge as the state register.
REQ-024 Output levels per state: cpu_resetq=1 only in RUN; done=1 only in RUN; err=1 only in FAIL; busy=1 in LEN_LO through SUM_HI.
REQ-025 boot_req=1 in any state: at the next edge, state becomes LEN_LO, the word index and sum clear, and cpu_resetq=0.
REQ-026 boot_req has priority over a simultaneous byte transfer; that byte is not consumed.
REQ-027 code_we is never asserted outside the cycle after a DAT_HI accept, and is never asserted in RUN or FAIL.
REQ-028 The word index is CODE_AW+1 bits wide so that N=CODE_DEPTH loads without wrap; code_waddr carries the low CODE_AW bits.
REQ-029 rx_valid low stalls the machine indefinitely in its current state with no timeout; outputs hold.

Reset
REQ-030 Asynchronous assertion and synchronous deassertion of resetq are assumed from the reset tree; the block only requires asynchronous assertion.
REQ-031 Reset values: state=LEN_LO, index=0, sum=0, code_we=0, code_waddr=0, code_wdata=0, cpu_resetq=0, busy=1, done=0, err=0.
REQ-032 A loading sequence interrupted by resetq restarts from LEN_LO; partially written RAM contents are don't-care.

Structure
REQ-033 Shared package j1_boot_pkg holds the state enumeration, the LEN/SUM field byte order constant, and CODE_AW/CODE_DEPTH defaults.
REQ-034 Single module; no sub-module, since byte-pair assembly is one 8-bit holding register inside the FSM.

Verification
REQ-035 Stream 02 00 34 12 78 56 AC 68 -> writes 0x1234@0 and 0x5678@1, one code_we cycle each; done=1, cpu_resetq=1.
REQ-036 Stream 01 00 FF FF 00 00 -> err=1, cpu_resetq stays 0, rx_ready=0; then boot_req plus a valid stream -> done=1.
REQ-037 Stream 01 20 (N=8193, CODE_DEPTH=8192) -> FAIL after 2 bytes; zero code_we pulses.
REQ-038 Stream 00 00 00 00 -> RUN with no writes; full 8192-word image -> last write at address 0x1FFF, then RUN.
REQ-039 boot_req asserted in the same cycle as a valid DAT_HI byte -> byte not consumed, no code_we, LEN_LO next cycle, index 0.
REQ-040 resetq pulsed low mid-DAT_LO, and rx_valid toggled randomly during a load -> reset values appear immediately; stalls do not alter the written data or addresses.
